// File: rtl/axis_string_to_axis_packet.sv
// ASCII command-string parser: turns "#hex", "&hex", "*hex" tokens separated by
// DELIMITER and closed by TERMINATION into AXI-Stream beats with sticky
// tdest/tuser. Malformed tokens pulse parse_error and discard the rest of the line.
module axis_string_to_axis_packet #(
  parameter logic [7:0] DELIMITER   = ";",
  parameter logic [7:0] TERMINATION = "\n",
  parameter int         MBUS_WIDTH  = 2,
  parameter int         USER_WIDTH  = 4,
  parameter int         DEST_WIDTH  = 4,
  parameter logic [7:0] DATA_PREFIX = "#",
  parameter logic [7:0] DEST_PREFIX = "&",
  parameter logic [7:0] USER_PREFIX = "*"
) (
  input  logic                      aclk,
  input  logic                      arstn,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [MBUS_WIDTH*8-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser,
  output logic [DEST_WIDTH-1:0]     m_axis_tdest,
  output logic                      parse_error
);

  localparam int DW  = MBUS_WIDTH * 8;
  // accumulator wide enough for the output bus and for either sideband field
  localparam int AW0 = (DW > DEST_WIDTH) ? DW : DEST_WIDTH;
  localparam int AW  = (AW0 > USER_WIDTH) ? AW0 : USER_WIDTH;
  localparam int CW  = 5;
  localparam logic [CW-1:0] MAXD = CW'(2 * MBUS_WIDTH);
  localparam logic [CW-1:0] SATD = CW'(2 * MBUS_WIDTH + 1);
  localparam logic [7:0]    CR   = 8'h0D;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_DEST, S_USER, S_ERR} state_t;

  state_t                state, state_n;
  logic [AW-1:0]         acc, acc_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DEST_WIDTH-1:0] dest_reg;
  logic [USER_WIDTH-1:0] user_reg;
  logic                  err_n, load_beat, load_dest, load_user, last_n;
  logic                  accept;
  logic                  is_end;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
  endfunction

  // 'a'..'f' and 'A'..'F' both have low nibble 1..6, so +9 maps them to 10..15
  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    if (b >= "0" && b <= "9") return b[3:0];
    else return b[3:0] + 4'd9;
  endfunction

  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign is_end        = (s_axis_tdata == DELIMITER) || (s_axis_tdata == TERMINATION);

  // Next-state, accumulator and token-completion decode for the consumed byte
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    err_n     = 1'b0;
    load_beat = 1'b0;
    load_dest = 1'b0;
    load_user = 1'b0;
    last_n    = 1'b0;
    if (accept && s_axis_tdata != CR) begin
      case (state)
        S_IDLE: begin
          if (s_axis_tdata == DATA_PREFIX)      state_n = S_DATA;
          else if (s_axis_tdata == DEST_PREFIX) state_n = S_DEST;
          else if (s_axis_tdata == USER_PREFIX) state_n = S_USER;
          else if (!is_end) begin
            state_n = S_ERR;
            err_n   = 1'b1;
          end
        end
        S_DATA, S_DEST, S_USER: begin
          if (is_hex(s_axis_tdata)) begin
            acc_n = {acc[AW-5:0], hex_nibble(s_axis_tdata)};
            cnt_n = (cnt == SATD) ? cnt : cnt + 1'b1;
          end else begin
            acc_n = '0;
            cnt_n = '0;
            if (is_end && cnt != '0 && cnt <= MAXD) begin
              state_n = S_IDLE;
              case (state)
                S_DATA: begin
                  load_beat = 1'b1;
                  last_n    = (s_axis_tdata == TERMINATION);
                end
                S_DEST:  load_dest = 1'b1;
                default: load_user = 1'b1;
              endcase
            end else begin
              err_n   = 1'b1;
              state_n = (s_axis_tdata == TERMINATION) ? S_IDLE : S_ERR;
            end
          end
        end
        default: begin
          if (s_axis_tdata == TERMINATION) state_n = S_IDLE;
        end
      endcase
    end
  end

  // Parser state, accumulator, error pulse and sticky sideband registers
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      parse_error <= 1'b0;
      dest_reg    <= '0;
      user_reg    <= '0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      parse_error <= err_n;
      if (load_dest) dest_reg <= acc[DEST_WIDTH-1:0];
      if (load_user) user_reg <= acc[USER_WIDTH-1:0];
    end
  end

  // Output beat register; a new beat can only load when the previous one is gone
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tdest  <= '0;
    end else if (load_beat) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= acc[DW-1:0];
      m_axis_tlast  <= last_n;
      m_axis_tuser  <= user_reg;
      m_axis_tdest  <= dest_reg;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_string_to_axis_packet.sv
// Directed bench for axis_string_to_axis_packet: a line-level token model predicts
// beats and error pulses; a per-cycle monitor compares the DUT stream against it.
module tb_axis_string_to_axis_packet;

  logic        aclk = 1'b0;
  logic        arstn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tuser;
  logic [3:0]  m_axis_tdest;
  logic        parse_error;

  axis_string_to_axis_packet dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tdest  (m_axis_tdest),
    .parse_error   (parse_error)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic [3:0]  u;
    logic [3:0]  t;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_err = 0;
  int    obs_err = 0;
  logic [3:0] mdl_user = 4'h0;
  logic [3:0] mdl_dest = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_hex(input byte c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic int hex_val(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return int'(c) - 55;
  endfunction

  // Line-level model: strip CR, split on ';' and '\n'; empty tokens are skipped;
  // the first malformed token costs one error and drops the rest of the line.
  task automatic model_line(input string s);
    byte q[$];
    int  st;
    byte p;
    int  val;
    bit  ok;
    for (int i = 0; i < s.len(); i++)
      if (s[i] != 8'h0D) q.push_back(s[i]);
    st = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == ";" || q[i] == "\n") begin
        if (i > st) begin
          p   = q[st];
          ok  = (p == "#" || p == "&" || p == "*") && (i - st - 1 >= 1) && (i - st - 1 <= 4);
          val = 0;
          for (int k = st + 1; k < i; k++) begin
            if (!is_hex(q[k])) ok = 1'b0;
            else val = val * 16 + hex_val(q[k]);
          end
          if (!ok) begin
            exp_err++;
            return;
          end
          if (p == "#") exp_q.push_back('{d: val[15:0], l: (q[i] == "\n"), u: mdl_user, t: mdl_dest});
          else if (p == "&") mdl_dest = val[3:0];
          else mdl_user = val[3:0];
        end
        st = i + 1;
      end
    end
  endtask

  task automatic send_byte(input byte b);
    int n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        chk("s_ready_timeout", 32'(s_axis_tready), 32'd1);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge aclk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 100) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(posedge aclk);
    #1;
    chk({name, "_pending_beats"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_error_pulses"}, 32'(obs_err), 32'(exp_err));
  endtask

  task automatic run_line(input string name, input string s);
    model_line(s);
    send_str(s);
    drain(name);
  endtask

  // Per-cycle monitor: handshake rule, hold-stability while stalled, beat compare
  logic        stall_prev = 1'b0;
  logic [15:0] pd;
  logic        pl;
  logic [3:0]  pu, pt;
  beat_t       e;
  always @(negedge aclk) begin
    if (!arstn) begin
      stall_prev = 1'b0;
    end else begin
      if (parse_error) obs_err++;
      chk("s_ready_rule", 32'(s_axis_tready), 32'(!m_axis_tvalid || m_axis_tready));
      if (stall_prev) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data", 32'(m_axis_tdata), 32'(pd));
        chk("hold_last", 32'(m_axis_tlast), 32'(pl));
        chk("hold_side", {24'd0, m_axis_tuser, m_axis_tdest}, {24'd0, pu, pt});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data 0x%0h last %0d, expected no beat at %0t",
                   m_axis_tdata, m_axis_tlast, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_axis_tdata), 32'(e.d));
          chk("beat_last", 32'(m_axis_tlast), 32'(e.l));
          chk("beat_user", 32'(m_axis_tuser), 32'(e.u));
          chk("beat_dest", 32'(m_axis_tdest), 32'(e.t));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; pl = m_axis_tlast; pu = m_axis_tuser; pt = m_axis_tdest;
    end
  end

  task automatic chk_outputs_zero(input string name);
    chk({name, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({name, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    chk({name, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({name, "_tuser"}, 32'(m_axis_tuser), 32'd0);
    chk({name, "_tdest"}, 32'(m_axis_tdest), 32'd0);
    chk({name, "_perr"}, 32'(parse_error), 32'd0);
    chk({name, "_s_ready"}, 32'(s_axis_tready), 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk_outputs_zero("reset");
    arstn = 1'b1;
    @(posedge aclk);
    #1;

    // two data beats on one line
    model_line("#1234;#ab\n");
    chk("pin1_count", 32'(exp_q.size()), 32'd2);
    chk("pin1_d0", 32'(exp_q[0].d), 32'h1234);
    chk("pin1_l0", 32'(exp_q[0].l), 32'd0);
    chk("pin1_d1", 32'(exp_q[1].d), 32'h00ab);
    chk("pin1_l1", 32'(exp_q[1].l), 32'd1);
    send_str("#1234;#ab\n");
    drain("line_basic");

    // sticky dest/user, CR ignored
    model_line("&5;*A;#0f\r\n");
    chk("pin2_beat", {exp_q[0].d, 7'd0, exp_q[0].l, exp_q[0].u, exp_q[0].t}, {16'h000f, 7'd0, 1'b1, 4'ha, 4'h5});
    send_str("&5;*A;#0f\r\n");
    drain("line_sticky");
    model_line("#1\n");
    chk("pin3_side", {24'd0, exp_q[0].u, exp_q[0].t}, {24'd0, 4'ha, 4'h5});
    send_str("#1\n");
    drain("line_keep");

    // bad hex digit drops the whole line, next line fine
    model_line("#12g4;#1\n");
    chk("pin4_count", 32'(exp_q.size()), 32'd0);
    chk("pin4_err", 32'(exp_err), 32'(obs_err + 1));
    send_str("#12g4;#1\n");
    drain("line_badhex");
    run_line("line_after_err", "#7\n");

    // too many digits, zero digits, empty dest, unknown prefix, max-width value
    run_line("line_long", "#12345;\n");
    run_line("line_empty", "#;\n");
    run_line("line_empty_dest", "&\n");
    run_line("line_badprefix", "x1;#2\n");
    model_line("#3\n");
    chk("pin5_dest", 32'(exp_q[0].t), 32'h5);
    send_str("#3\n");
    drain("line_dest_kept");
    run_line("line_max", ";;#FfFf;*3\n#c;&9\n");
    run_line("line_keep2", "#0;#00\n");

    // downstream stall
    model_line("#11;#22\n");
    m_axis_tready = 1'b0;
    fork
      send_str("#11;#22\n");
      begin
        repeat (20) @(posedge aclk);
        #1;
        chk("stall_s_ready", 32'(s_axis_tready), 32'd0);
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", 32'(m_axis_tdata), 32'h0011);
        m_axis_tready = 1'b1;
      end
    join
    drain("line_stall");

    // reset in the middle of a token
    send_str("#12");
    #2 arstn = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    mdl_user = 4'h0;
    mdl_dest = 4'h0;
    @(posedge aclk);
    #1 arstn = 1'b1;
    model_line("#5\n");
    chk("pin6_beat", {exp_q[0].d, 7'd0, exp_q[0].l, exp_q[0].u, exp_q[0].t}, {16'h0005, 7'd0, 1'b1, 4'h0, 4'h0});
    send_str("#5\n");
    drain("line_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_string_to_axis_packet.md
AXIS_STRING_TO_AXIS_PACKET -- requirements
Module: axis_string_to_axis_packet

Interface
REQ-001 SHALL provide parameter DELIMITER, default ";", token separator byte.
REQ-002 SHALL provide parameter TERMINATION, default "\n", line terminator byte.
REQ-003 SHALL provide parameter MBUS_WIDTH, default 2, output data width in bytes (1..8).
REQ-004 SHALL provide parameter USER_WIDTH, default 4, tuser width in bits (1..32).
REQ-005 SHALL provide parameter DEST_WIDTH, default 4, tdest width in bits (1..32).
REQ-006 SHALL provide parameters DATA_PREFIX "#", DEST_PREFIX "&", USER_PREFIX "*", each one byte, token type selectors.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: aclk  input  1  clock; arstn  input  1  async active-low reset.
REQ-008 s_axis_tdata  input  8  ASCII byte in.
REQ-009 s_axis_tvalid  input  1  input byte valid.
REQ-010 s_axis_tready  output  1  input byte accepted.
REQ-011 m_axis_tdata  output  MBUS_WIDTH*8  parsed value, right-justified.
REQ-012 m_axis_tvalid  output  1  output beat valid.
REQ-013 m_axis_tready  input  1  downstream ready.
REQ-014 m_axis_tlast  output  1  beat closed by TERMINATION.
REQ-015 m_axis_tuser  output  USER_WIDTH  current sticky user value.
REQ-016 m_axis_tdest  output  DEST_WIDTH  current sticky dest value.
REQ-017 parse_error  output  1  one-cycle pulse on malformed token.

Function
REQ-018 SHALL consume an input byte only on s_axis_tvalid & s_axis_tready; s_axis_tready = ~m_axis_tvalid | m_axis_tready.
REQ-019 SHALL implement states IDLE, DATA, DEST, USER, ERR.
REQ-020 IDLE: DATA_PREFIX -> DATA, DEST_PREFIX -> DEST, USER_PREFIX -> USER, DELIMITER/TERMINATION/0x0D -> stay, any other byte -> ERR with parse_error.
REQ-021 DATA/DEST/USER: hex digit (0-9, a-f, A-F) -> accumulator = (acc << 4) | nibble, digit count +1, saturating at 2*MBUS_WIDTH+1.
REQ-022 SHALL ignore 0x0D in every state.
REQ-023 Token end (DELIMITER or TERMINATION) with 1..2*MBUS_WIDTH digits: DATA loads output register, sets m_axis_tvalid next cycle, m_axis_tlast = (end byte == TERMINATION); DEST loads dest register with acc[DEST_WIDTH-1:0]; USER loads user register with acc[USER_WIDTH-1:0]; then -> IDLE, accumulator and count cleared.
REQ-024 Token end with zero digits, digit count > 2*MBUS_WIDTH, or any non-hex byte -> parse_error one cycle, no beat, no register update, -> ERR (or IDLE directly if the byte is TERMINATION).
REQ-025 ERR: discard bytes until TERMINATION consumed, then -> IDLE; no beats emitted.
REQ-026 Beats emitted earlier on the same line SHALL stand after a later error.
REQ-027 m_axis_tuser/m_axis_tdest SHALL be sampled into the output register with tdata and held stable while m_axis_tvalid & ~m_axis_tready.
REQ-028 m_axis_tvalid SHALL clear on m_axis_tready unless a new DATA token ends in the same cycle (back-to-back beats allowed).
REQ-029 TERMINATION ending a DEST/USER token SHALL produce no beat and no retroactive tlast.
REQ-030 Latency: m_axis_tvalid high the cycle after the token-ending byte is consumed.

Reset
REQ-031 arstn low SHALL asynchronously force: state IDLE, accumulator 0, digit count 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0, m_axis_tdest 0, parse_error 0; s_axis_tready follows REQ-018 (1).
REQ-032 Reset mid-token SHALL discard the partial token; parsing restarts in IDLE.

Verification (MBUS_WIDTH=2)
REQ-033 "#1234;#ab\n", tready=1 -> beats 0x1234 tlast=0, 0x00AB tlast=1; parse_error never high.
REQ-034 "&5;*A;#0f\n" -> one beat 0x000F, tdest=0x5, tuser=0xA, tlast=1; next line "#1\n" keeps tdest=0x5, tuser=0xA.
REQ-035 "#12g4;#1\n" then "#7\n" -> parse_error pulse on 'g', no beats for line 1, beat 0x0007 tlast=1.
REQ-036 "#12345;\n" and "#;\n" -> parse_error pulse each, no beats; "&\n" -> parse_error, tdest unchanged.
REQ-037 "#11;#22\n" with m_axis_tready low 20 cycles -> s_axis_tready low while beat held, tdata 0x0011 stable, then 0x0011, 0x0022 delivered in order, none lost.
REQ-038 Assert arstn low after "#12" of "#1234\n" -> all outputs zero; after release, "#5\n" -> beat 0x0005 tlast=1.
